// File: rtl/bitwise_ops.sv
// Registered two-operand bitwise logic unit: AND, OR, NAND, NOR, XOR and XNOR
// of two WIDTH-bit operands, all captured together with one cycle of latency.
module bitwise_ops #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] aandb,
    output logic [WIDTH-1:0] aorb,
    output logic [WIDTH-1:0] anandb,
    output logic [WIDTH-1:0] anorb,
    output logic [WIDTH-1:0] axorb,
    output logic [WIDTH-1:0] axnorb
);

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] aandb_d,  aandb_q;
    logic [WIDTH-1:0] aorb_d,   aorb_q;
    logic [WIDTH-1:0] anandb_d, anandb_q;
    logic [WIDTH-1:0] anorb_d,  anorb_q;
    logic [WIDTH-1:0] axorb_d,  axorb_q;
    logic [WIDTH-1:0] axnorb_d, axnorb_q;

    // Results hold their last value while idle; only the valid flag drops.
    always_comb begin
        out_valid_d = 1'b0;
        aandb_d     = aandb_q;
        aorb_d      = aorb_q;
        anandb_d    = anandb_q;
        anorb_d     = anorb_q;
        axorb_d     = axorb_q;
        axnorb_d    = axnorb_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
            aandb_d     = a & b;
            aorb_d      = a | b;
            anandb_d    = ~(a & b);
            anorb_d     = ~(a | b);
            axorb_d     = a ^ b;
            axnorb_d    = ~(a ^ b);
        end
    end

    // Reset clears every result to 0, including the inverted ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            aandb_q     <= '0;
            aorb_q      <= '0;
            anandb_q    <= '0;
            anorb_q     <= '0;
            axorb_q     <= '0;
            axnorb_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            aandb_q     <= aandb_d;
            aorb_q      <= aorb_d;
            anandb_q    <= anandb_d;
            anorb_q     <= anorb_d;
            axorb_q     <= axorb_d;
            axnorb_q    <= axnorb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign aandb     = aandb_q;
    assign aorb      = aorb_q;
    assign anandb    = anandb_q;
    assign anorb     = anorb_q;
    assign axorb     = axorb_q;
    assign axnorb    = axnorb_q;

endmodule

// File: tb/tb_bitwise_ops.sv
// Self-checking bench for bitwise_ops: expected results are queued as stimulus
// is driven and popped one cycle later when the registered outputs appear.
module tb_bitwise_ops;

    localparam int unsigned W = 4;
    typedef logic [6*W:0] res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic [W-1:0] aandb, aorb, anandb, anorb, axorb, axnorb;

    res_t         sb[$];
    logic [6*W-1:0] model_q = '0;
    int           n_checks = 0;
    int           n_fail = 0;
    res_t         obs;

    bitwise_ops #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .aandb    (aandb),
        .aorb     (aorb),
        .anandb   (anandb),
        .anorb    (anorb),
        .axorb    (axorb),
        .axnorb   (axnorb)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid, aandb, aorb, anandb, anorb, axorb, axnorb};

    // Drive one cycle of stimulus at negedge, push the expectation, then
    // return #1 after the capturing posedge.
    task automatic drive(input logic rst, input logic vld,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        res_t e;
        @(negedge clk);
        rst_n = rst; in_valid = vld; a = av; b = bv;
        if (!rst) begin
            model_q = '0;
            e = '0;
        end else if (vld) begin
            model_q = {av & bv, av | bv, ~(av & bv), ~(av | bv), av ^ bv, ~(av ^ bv)};
            e = {1'b1, model_q};
        end else begin
            e = {1'b0, model_q};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t e;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 4'hF, 4'hF);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL reset: scoreboard empty, got %h", obs);
            end else begin
                e = sb.pop_front();
                if (obs !== e || obs !== '0) begin
                    n_fail++; $display("FAIL reset[%0d]: got %h want %h", k, obs, e);
                end
            end
        end
    endtask

    task automatic test_single();
        res_t e;
        drive(1'b1, 1'b1, 4'b1100, 4'b1010);
        n_checks++;
        e = sb.pop_front();
        if (obs !== e || obs !== 25'h18E7169) begin
            n_fail++; $display("FAIL single: got %h want %h", obs, e);
        end
    endtask

    task automatic test_hold();
        res_t e;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'h0, 4'hF);
            n_checks++;
            e = sb.pop_front();
            if (obs !== e || obs !== 25'h08E7169) begin
                n_fail++; $display("FAIL hold[%0d]: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_sweep();
        res_t e;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive(1'b1, 1'b1, 4'(i), 4'(j));
                n_checks++;
                e = sb.pop_front();
                if (obs !== e) begin
                    n_fail++; $display("FAIL sweep a=%h b=%h: got %h want %h", i, j, obs, e);
                end
                n_checks++;
                if (out_valid !== 1'b1 || anandb !== ~aandb || anorb !== ~aorb ||
                    axnorb !== ~axorb || axorb !== (aorb & anandb)) begin
                    n_fail++;
                    $display("FAIL invariant a=%h b=%h: got %h want consistent set", i, j, obs);
                end
            end
        end
    endtask

    task automatic test_extremes();
        res_t e;
        drive(1'b1, 1'b1, 4'h0, 4'h0);
        n_checks++;
        e = sb.pop_front();
        if (obs !== e || obs !== 25'h100FF0F) begin
            n_fail++; $display("FAIL extreme_zero: got %h want %h", obs, e);
        end
        drive(1'b1, 1'b1, 4'hF, 4'hF);
        n_checks++;
        e = sb.pop_front();
        if (obs !== e || obs !== 25'h1FF000F) begin
            n_fail++; $display("FAIL extreme_ones: got %h want %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        logic [W-1:0] av, bv;
        for (int k = 0; k < 12; k++) begin
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            // Reset for one edge mid-stream, with a valid pair on the bus.
            drive((k == 5) ? 1'b0 : 1'b1, (k == 8) ? 1'b0 : 1'b1, av, bv);
            n_checks++;
            e = sb.pop_front();
            if (obs !== e) begin
                n_fail++; $display("FAIL stream[%0d]: got %h want %h", k, obs, e);
            end
            if (k == 5) begin
                n_checks++;
                if (obs !== '0) begin
                    n_fail++; $display("FAIL midreset: got %h want 0", obs);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF;
        test_reset();
        test_single();
        test_hold();
        test_sweep();
        test_extremes();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
